alu_issue_unit: RTL and testbench
=================================

Name: alu_issue_unit

Overview:
- Initiator for the 2-bit-opcode ALU interface (op, a, b -> out). It accepts register-level commands over a valid/ready port and holds a small register file.
- It drives the ALU's op/a/b inputs, samples the ALU result and writes it back to the register file.
- It returns the result on a valid/ready response port. Sits between a command source (testbench/controller) and a combinational ALU instance.

Parameters:
- WIDTH, 8, data width of registers, ALU operands and result.
- NREGS, 4, number of registers; register index width RIDX = clog2(NREGS).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  unit can accept command
- cmd_imm_sel  input  1  1 = load immediate, 0 = ALU operation
- cmd_op  input  2  ALU opcode: 00 add, 01 sub, 10 and, 11 or
- cmd_rd  input  RIDX  destination register
- cmd_rs1  input  RIDX  operand A register
- cmd_rs2  input  RIDX  operand B register
- cmd_imm  input  WIDTH  immediate value
- alu_op  output  2  opcode to ALU
- alu_a  output  WIDTH  operand A to ALU
- alu_b  output  WIDTH  operand B to ALU
- alu_out  input  WIDTH  ALU result (combinational from alu_op/a/b)
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_rd  output  RIDX  register written
- rsp_data  output  WIDTH  value written

Behaviour:
- One clock (clk); rst synchronous, active-high.
- FSM states: IDLE, ISSUE, RESP.
- Reset: state=IDLE; all registers=0; alu_op=0, alu_a=0, alu_b=0; rsp_valid=0, rsp_rd=0, rsp_data=0; cmd_ready=1 in the cycle after reset.
- cmd_ready = (state==IDLE); combinational from state only, never from cmd_valid.
- IDLE, cmd_valid=1, cmd_imm_sel=1:
  - reg[cmd_rd] <= cmd_imm; rsp_rd <= cmd_rd; rsp_data <= cmd_imm; -> RESP.
  - Latency: rsp_valid high 1 cycle after accept.
- IDLE, cmd_valid=1, cmd_imm_sel=0:
  - alu_op <= cmd_op; alu_a <= reg[cmd_rs1]; alu_b <= reg[cmd_rs2]; latch cmd_rd; -> ISSUE.
- ISSUE: one cycle; ALU settles combinationally. At the clock edge:
  - reg[rd] <= alu_out; rsp_data <= alu_out; rsp_rd <= rd; -> RESP.
  - Latency: rsp_valid high 2 cycles after accept.
- RESP: rsp_valid=1; rsp_rd/rsp_data held stable until handshake.
  - rsp_ready=1 -> IDLE, rsp_valid drops next cycle.
  - rsp_ready may be high before rsp_valid; the handshake still completes in the first RESP cycle.
- alu_op/alu_a/alu_b are registered and hold their last issued values outside ISSUE; not updated by immediate loads.
- Arithmetic: result is alu_out truncated to WIDTH; add/sub wrap modulo 2^WIDTH; no carry/borrow is kept.
- rs1, rs2 and rd may alias; operands are read at accept, before write-back, so the old value is used.
- cmd_valid while not IDLE: ignored (cmd_ready=0); the source must hold the command.
- Reset mid-operation (ISSUE or RESP): in-flight command dropped, no write-back, no response, all state per reset list.
- Throughput: at most 1 command per 2 cycles (immediate) or 3 cycles (ALU), assuming rsp_ready=1.

Optional Feature:
- Macro ALU_ISSUE_FLAGS_EN.
- Defined: adds outputs rsp_zero (1) and rsp_neg (1), registered alongside rsp_data and valid with rsp_valid.
  - rsp_zero = (rsp_data==0); rsp_neg = rsp_data[WIDTH-1].
  - Both apply to immediates too; both reset to 0.
- Undefined: ports absent; no flag logic.

Test Plan:
- Reset then idle -> all outputs 0, cmd_ready=1, rsp_valid=0; regs read 0 via ADD r0=r1+r2 -> rsp_data=0.
- LI r1=200, LI r2=100, ADD r3=r1+r2 (op 00) -> rsp_data=44 (wrap), rsp_rd=3; alu_a=200, alu_b=100 during ISSUE; rsp_valid exactly 2 cycles after accept.
- LI r0=5, LI r1=7, SUB r2=r0-r1 (op 01) -> rsp_data=254; with ALU_ISSUE_FLAGS_EN: rsp_neg=1, rsp_zero=0.
- LI r0=0xF0, LI r1=0x3C; AND r2 (op 10) -> 0x30; OR r3 (op 11) -> 0xFC; AND r0=r0&r0 (aliasing) -> 0xF0 written to r0.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_data stable, cmd_ready=0, second cmd_valid ignored; rsp_ready=1 -> IDLE next cycle, then second command accepted.
- Assert rst during ISSUE of ADD r3 -> no response, r3 reads 0 afterwards, alu_a/alu_b=0, cmd_ready=1 after reset.

Source files
------------

// File: rtl/alu_issue_unit.sv
// Issue unit for a 2-bit-opcode combinational ALU: register file, valid/ready command and response ports.
// Optional macro ALU_ISSUE_FLAGS_EN adds registered rsp_zero/rsp_neg response flags.
module alu_issue_unit #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    localparam int RIDX = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_imm_sel,
    input  logic [1:0]       cmd_op,
    input  logic [RIDX-1:0]  cmd_rd,
    input  logic [RIDX-1:0]  cmd_rs1,
    input  logic [RIDX-1:0]  cmd_rs2,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [RIDX-1:0]  rsp_rd,
`ifdef ALU_ISSUE_FLAGS_EN
    output logic             rsp_zero,
    output logic             rsp_neg,
`endif
    output logic [WIDTH-1:0] rsp_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t                        state_q, state_d;
    logic [NREGS-1:0][WIDTH-1:0]   regs_q, regs_d;
    logic [RIDX-1:0]               rd_q, rd_d;
    logic [1:0]                    alu_op_q, alu_op_d;
    logic [WIDTH-1:0]              alu_a_q, alu_a_d;
    logic [WIDTH-1:0]              alu_b_q, alu_b_d;
    logic [RIDX-1:0]               rsp_rd_q, rsp_rd_d;
    logic [WIDTH-1:0]              rsp_data_q, rsp_data_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            regs_q     <= '0;
            rd_q       <= '0;
            alu_op_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            rsp_rd_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            regs_q     <= regs_d;
            rd_q       <= rd_d;
            alu_op_q   <= alu_op_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            rsp_rd_q   <= rsp_rd_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Operands are captured at accept, so aliased rd/rs see the pre-write-back value.
    always_comb begin
        state_d    = state_q;
        regs_d     = regs_q;
        rd_d       = rd_q;
        alu_op_d   = alu_op_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        rsp_rd_d   = rsp_rd_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_imm_sel) begin
                        regs_d[cmd_rd] = cmd_imm;
                        rsp_rd_d       = cmd_rd;
                        rsp_data_d     = cmd_imm;
                        state_d        = RESP;
                    end else begin
                        alu_op_d = cmd_op;
                        alu_a_d  = regs_q[cmd_rs1];
                        alu_b_d  = regs_q[cmd_rs2];
                        rd_d     = cmd_rd;
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                regs_d[rd_q] = alu_out;
                rsp_rd_d     = rd_q;
                rsp_data_d   = alu_out;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rsp_rd    = rsp_rd_q;
    assign rsp_data  = rsp_data_q;

`ifdef ALU_ISSUE_FLAGS_EN
    logic zero_q, zero_d, neg_q, neg_d;

    // Flags are refreshed only when a new response is produced (entry into RESP).
    always_comb begin
        zero_d = zero_q;
        neg_d  = neg_q;
        if (state_d == RESP && state_q != RESP) begin
            zero_d = (rsp_data_d == '0);
            neg_d  = rsp_data_d[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            neg_q  <= neg_d;
        end
    end

    assign rsp_zero = zero_q;
    assign rsp_neg  = neg_q;
`endif

endmodule

// File: tb/tb_alu_issue_unit.sv
// Randomized + directed bench for alu_issue_unit against a transaction-level reference model.
module tb_alu_issue_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_imm_sel;
    logic [1:0] cmd_op, cmd_rd, cmd_rs1, cmd_rs2;
    logic [7:0] cmd_imm;
    logic [1:0] alu_op;
    logic [7:0] alu_a, alu_b, alu_out;
    logic       rsp_valid, rsp_ready;
    logic [1:0] rsp_rd;
    logic [7:0] rsp_data;
`ifdef ALU_ISSUE_FLAGS_EN
    logic       rsp_zero, rsp_neg;
`endif

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_issue_unit #(.WIDTH(8), .NREGS(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_imm_sel(cmd_imm_sel),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_imm(cmd_imm),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd),
`ifdef ALU_ISSUE_FLAGS_EN
        .rsp_zero(rsp_zero), .rsp_neg(rsp_neg),
`endif
        .rsp_data(rsp_data)
    );

    function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    // The combinational ALU the unit drives.
    always_comb alu_out = alu_f(alu_op, alu_a, alu_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: busy from accept until response handshake; ALU results land one edge after accept.
    logic [7:0] m_regs [4];
    bit         m_busy, m_resp;
    logic [1:0] m_op, m_rd, p_rd;
    logic [7:0] m_a, m_b, m_data, p_data;
`ifdef ALU_ISSUE_FLAGS_EN
    bit         m_zero, m_neg;
`endif

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 0; m_resp <= 0;
            m_op <= 0; m_a <= 0; m_b <= 0; m_rd <= 0; m_data <= 0;
            p_rd <= 0; p_data <= 0;
            for (int i = 0; i < 4; i++) m_regs[i] <= 8'd0;
`ifdef ALU_ISSUE_FLAGS_EN
            m_zero <= 0; m_neg <= 0;
`endif
        end else if (m_resp) begin
            if (rsp_ready) begin m_resp <= 0; m_busy <= 0; end
        end else if (m_busy) begin
            m_resp <= 1; m_regs[p_rd] <= p_data; m_rd <= p_rd; m_data <= p_data;
`ifdef ALU_ISSUE_FLAGS_EN
            m_zero <= (p_data == 0); m_neg <= p_data[7];
`endif
        end else if (cmd_valid) begin
            m_busy <= 1;
            if (cmd_imm_sel) begin
                m_regs[cmd_rd] <= cmd_imm; m_resp <= 1; m_rd <= cmd_rd; m_data <= cmd_imm;
`ifdef ALU_ISSUE_FLAGS_EN
                m_zero <= (cmd_imm == 0); m_neg <= cmd_imm[7];
`endif
            end else begin
                m_op <= cmd_op; m_a <= m_regs[cmd_rs1]; m_b <= m_regs[cmd_rs2];
                p_rd <= cmd_rd; p_data <= alu_f(cmd_op, m_regs[cmd_rs1], m_regs[cmd_rs2]);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_ready", cmd_ready, !m_busy);
            chk("rsp_valid", rsp_valid, m_resp);
            chk("rsp_rd",    rsp_rd,    m_rd);
            chk("rsp_data",  rsp_data,  m_data);
            chk("alu_op",    alu_op,    m_op);
            chk("alu_a",     alu_a,     m_a);
            chk("alu_b",     alu_b,     m_b);
`ifdef ALU_ISSUE_FLAGS_EN
            chk("rsp_zero",  rsp_zero,  m_zero);
            chk("rsp_neg",   rsp_neg,   m_neg);
`endif
        end
    end

    // lat = negedges from accept until rsp_valid seen (0 for immediate, 1 for ALU).
    task automatic run_cmd(input logic imm_sel, input logic [1:0] op, input logic [1:0] rd,
                           input logic [1:0] rs1, input logic [1:0] rs2, input logic [7:0] imm,
                           input int bp, output logic [7:0] data, output logic [1:0] rrd, output int lat);
        int n;
        @(negedge clk);
        cmd_imm_sel = imm_sel; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
        cmd_valid = 1'b1; rsp_ready = (bp == 0);
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("accept_timeout", 1, 0);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_imm_sel = 1'($urandom); cmd_op = 2'($urandom); cmd_rd = 2'($urandom);
        cmd_rs1 = 2'($urandom); cmd_rs2 = 2'($urandom); cmd_imm = 8'($urandom);
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("rsp_timeout", 1, 0);
        lat = n;
        repeat (bp) @(negedge clk);
        rsp_ready = 1'b1; data = rsp_data; rrd = rsp_rd;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [7:0] d;
        logic [1:0] r;
        int         lat;
        rst = 1'b1; cmd_valid = 0; cmd_imm_sel = 0; cmd_op = 0; cmd_rd = 0;
        cmd_rs1 = 0; cmd_rs2 = 0; cmd_imm = 0; rsp_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; chk_en = 1'b1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_rsp_data", rsp_data, 0);

        run_cmd(0, 2'd0, 2'd0, 2'd1, 2'd2, 8'd0, 0, d, r, lat);
        chk("add_zero_regs", d, 8'd0);

        run_cmd(1, 2'd0, 2'd1, 2'd0, 2'd0, 8'd200, 0, d, r, lat);
        chk("li_lat", lat, 0);
        run_cmd(1, 2'd0, 2'd2, 2'd0, 2'd0, 8'd100, 1, d, r, lat);
        run_cmd(0, 2'd0, 2'd3, 2'd1, 2'd2, 8'd0, 0, d, r, lat);
        chk("add_wrap", d, 8'd44);
        chk("add_rd", r, 2'd3);
        chk("add_lat", lat, 1);
        chk("add_alu_a", alu_a, 8'd200);
        chk("add_alu_b", alu_b, 8'd100);

        run_cmd(1, 2'd0, 2'd0, 2'd0, 2'd0, 8'd5, 0, d, r, lat);
        run_cmd(1, 2'd0, 2'd1, 2'd0, 2'd0, 8'd7, 0, d, r, lat);
        run_cmd(0, 2'd1, 2'd2, 2'd0, 2'd1, 8'd0, 2, d, r, lat);
        chk("sub_wrap", d, 8'd254);
`ifdef ALU_ISSUE_FLAGS_EN
        chk("sub_neg", rsp_neg, 1);
        chk("sub_zero", rsp_zero, 0);
`endif

        run_cmd(1, 2'd0, 2'd0, 2'd0, 2'd0, 8'hF0, 0, d, r, lat);
        run_cmd(1, 2'd0, 2'd1, 2'd0, 2'd0, 8'h3C, 0, d, r, lat);
        run_cmd(0, 2'd2, 2'd2, 2'd0, 2'd1, 8'd0, 0, d, r, lat);
        chk("and", d, 8'h30);
        run_cmd(0, 2'd3, 2'd3, 2'd0, 2'd1, 8'd0, 0, d, r, lat);
        chk("or", d, 8'hFC);
        run_cmd(0, 2'd2, 2'd0, 2'd0, 2'd0, 8'd0, 0, d, r, lat);
        chk("and_alias", d, 8'hF0);
        chk("and_alias_rd", r, 2'd0);

        // Backpressure with a second command held during RESP.
        @(negedge clk);
        cmd_imm_sel = 1; cmd_rd = 2'd1; cmd_imm = 8'h11; cmd_valid = 1; rsp_ready = 0;
        @(posedge clk);
        @(negedge clk);
        cmd_rd = 2'd2; cmd_imm = 8'h22;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_data", rsp_data, 8'h11);
            chk("bp_cmd_ready", cmd_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_idle_ready", cmd_ready, 1);
        chk("bp_idle_valid", rsp_valid, 0);
        rsp_ready = 0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0;
        chk("bp_second_data", rsp_data, 8'h22);
        chk("bp_second_rd", rsp_rd, 2'd2);
        rsp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 0;

        // Reset while an ADD is in ISSUE.
        run_cmd(1, 2'd0, 2'd1, 2'd0, 2'd0, 8'd1, 0, d, r, lat);
        run_cmd(1, 2'd0, 2'd2, 2'd0, 2'd0, 8'd2, 0, d, r, lat);
        @(negedge clk);
        cmd_imm_sel = 0; cmd_op = 2'd0; cmd_rd = 2'd3; cmd_rs1 = 2'd1; cmd_rs2 = 2'd2; cmd_valid = 1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0;
        chk("issue_alu_a", alu_a, 8'd1);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_alu_b", alu_b, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        chk("mid_rst_valid", rsp_valid, 0);
        run_cmd(0, 2'd3, 2'd0, 2'd3, 2'd3, 8'd0, 0, d, r, lat);
        chk("r3_after_rst", d, 8'd0);

        for (int i = 0; i < 250; i++) begin
            run_cmd(1'($urandom_range(0, 2) == 0), 2'($urandom), 2'($urandom), 2'($urandom),
                    2'($urandom), 8'($urandom), int'($urandom_range(0, 3)), d, r, lat);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
